// File: rtl/instruction_memory_responder_pkg.sv
// Shared definitions for the instruction-fetch memory responder:
// FSM state encodings, bus-width defaults and the idle bus value.
package instruction_memory_responder_pkg;

   localparam int AddressBusWidthDefault = 32;
   localparam int MemoryBusWidthDefault  = 32;
   localparam int CounterWidth           = 8;

   localparam logic [MemoryBusWidthDefault-1:0] MemoryBusZero = '0;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      ACK  = 2'b10
   } state_e;

endpackage

// File: rtl/instruction_memory_array.sv
// Word RAM with one write port and one synchronous read port.
// A read and a write to the same word on one edge return the old contents.
module instruction_memory_array
   import instruction_memory_responder_pkg::*;
#(
   parameter int DepthLog2 = 10,
   parameter int Width     = MemoryBusWidthDefault
) (
   input  logic                 clk,
   input  logic                 we_i,
   input  logic [DepthLog2-1:0] waddr_i,
   input  logic [Width-1:0]     wdata_i,
   input  logic                 re_i,
   input  logic [DepthLog2-1:0] raddr_i,
   output logic [Width-1:0]     rdata_o
);

   logic [Width-1:0] mem_q [0:(1<<DepthLog2)-1];
   logic [Width-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/instruction_memory_responder.sv
// Responder side of the instruction-fetch word protocol: serves single-word reads
// from a local program store with programmable (and shorter in-line sequential) wait states.
module instruction_memory_responder
   import instruction_memory_responder_pkg::*;
#(
   parameter int AddressBusWidth = AddressBusWidthDefault,
   parameter int MemoryBusWidth  = MemoryBusWidthDefault,
   parameter int MemoryDepthLog2 = 10,
   parameter int WaitStates      = 2,
   parameter int SeqWaitStates   = 0
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [AddressBusWidth-1:0] MemoryAddress,
   input  logic                       MemoryRequest,
   output logic [MemoryBusWidth-1:0]  MemoryBus,
   output logic                       nMemoryWait,
   input  logic                       LoadEnable,
   input  logic [AddressBusWidth-1:0] LoadAddress,
   input  logic [MemoryBusWidth-1:0]  LoadData
);

   state_e                     state_q;
   logic [CounterWidth-1:0]    cnt_q;
   logic [MemoryDepthLog2-1:0] index_q;
   logic [MemoryDepthLog2-1:0] last_word_q;
   logic                       seq_valid_q;
   logic                       ack_q;

   logic [MemoryDepthLog2-1:0] req_index;
   logic [MemoryDepthLog2-1:0] load_index;
   logic [MemoryDepthLog2-1:0] next_word;
   logic [MemoryDepthLog2-1:0] rd_index;
   logic                       is_seq;
   logic [CounterWidth-1:0]    start_cnt;
   logic                       rd_en;
   logic [MemoryBusWidth-1:0]  rd_data;

   // Address bits outside the word index are deliberately ignored (store wraps).
   logic unused_addr_bits;
   assign unused_addr_bits = ^{MemoryAddress[AddressBusWidth-1:MemoryDepthLog2+2], MemoryAddress[1:0],
                               LoadAddress[AddressBusWidth-1:MemoryDepthLog2+2], LoadAddress[1:0]};

   assign req_index  = MemoryAddress[MemoryDepthLog2+1:2];
   assign load_index = LoadAddress[MemoryDepthLog2+1:2];
   assign next_word  = last_word_q + 1'b1;

   // Sequential only when the next word stays inside the same 16-byte line.
   assign is_seq    = seq_valid_q && (req_index == next_word) && (MemoryAddress[3:2] != 2'b00);
   assign start_cnt = is_seq ? CounterWidth'(SeqWaitStates) : CounterWidth'(WaitStates);

   always_comb begin
      rd_en    = 1'b0;
      rd_index = index_q;
      if (state_q == IDLE) begin
         rd_index = req_index;
         rd_en    = MemoryRequest && (start_cnt == '0);
      end else if (state_q == WAIT) begin
         rd_en    = MemoryRequest && (cnt_q == CounterWidth'(1));
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         index_q     <= '0;
         last_word_q <= '0;
         seq_valid_q <= 1'b0;
         ack_q       <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (MemoryRequest) begin
                  index_q <= req_index;
                  cnt_q   <= start_cnt;
                  if (start_cnt == '0) begin
                     state_q <= ACK;
                     ack_q   <= 1'b1;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (!MemoryRequest) begin
                  state_q     <= IDLE;
                  cnt_q       <= '0;
                  seq_valid_q <= 1'b0;
               end else if (cnt_q == CounterWidth'(1)) begin
                  state_q <= ACK;
                  cnt_q   <= '0;
                  ack_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ACK: begin
               state_q     <= IDLE;
               last_word_q <= index_q;
               seq_valid_q <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
         // A preload may change the stream, so it breaks the sequential chain.
         if (LoadEnable) begin
            seq_valid_q <= 1'b0;
         end
      end
   end

   instruction_memory_array #(
      .DepthLog2 (MemoryDepthLog2),
      .Width     (MemoryBusWidth)
   ) u_array (
      .clk     (clock),
      .we_i    (LoadEnable),
      .waddr_i (load_index),
      .wdata_i (LoadData),
      .re_i    (rd_en),
      .raddr_i (rd_index),
      .rdata_o (rd_data)
   );

   assign nMemoryWait = ack_q;
   assign MemoryBus   = ack_q ? rd_data : MemoryBusWidth'(MemoryBusZero);

endmodule
